// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : mul_sched (+ calc_mul)
// Brief    : Two-requester round-robin scheduler around one shared 16x16
//            radix-4 Booth multiplier with per-requester result registers.
// Revision : 1.0 - initial release
// ============================================================================

module calc_mul (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [2:0]  m,
   input  logic        en,
   output logic [31:0] p
);
   logic [31:0] w_a32;
   logic [18:0] w_bz;
   logic [31:0] w_pp;
   logic [31:0] w_acc;

   // Operands are widened to 17-bit signed so one Booth array covers both
   // signed and unsigned modes; only the low 32 product bits are kept.
   always_comb begin
      w_a32 = {{16{a[15] & ~m[1]}}, a};
      w_bz  = {{2{b[15] & ~m[0]}}, b, 1'b0};
      w_pp  = '0;
      w_acc = '0;
      for (int j = 0; j < 9; j++) begin
         case (w_bz[2*j +: 3])
            3'b001, 3'b010: w_pp = w_a32;
            3'b011:         w_pp = w_a32 << 1;
            3'b100:         w_pp = -(w_a32 << 1);
            3'b101, 3'b110: w_pp = -w_a32;
            default:        w_pp = '0;
         endcase
         w_acc = w_acc + (w_pp << (2*j));
      end
      p = en ? (m[2] ? {16'h0, w_acc[31:16]} : w_acc) : '0;
   end
endmodule

module mul_sched (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        REQ0_VALID,
   input  logic        REQ1_VALID,
   output logic        REQ0_READY,
   output logic        REQ1_READY,
   input  logic [15:0] REQ0_A,
   input  logic [15:0] REQ1_A,
   input  logic [15:0] REQ0_B,
   input  logic [15:0] REQ1_B,
   input  logic [2:0]  REQ0_M,
   input  logic [2:0]  REQ1_M,
   input  logic        KILL0,
   input  logic        KILL1,
   output logic        RSP0_VALID,
   output logic        RSP1_VALID,
   input  logic        RSP0_READY,
   input  logic        RSP1_READY,
   output logic [31:0] RSP0_DATA,
   output logic [31:0] RSP1_DATA,
   output logic        BUSY
);
   logic        r_s1_valid;
   logic        r_s1_owner;
   logic [15:0] r_s1_a;
   logic [15:0] r_s1_b;
   logic [2:0]  r_s1_m;
   logic        r_r0_valid;
   logic [31:0] r_r0_data;
   logic        r_r1_valid;
   logic [31:0] r_r1_data;
   logic        r_pri;

   logic        w_drain0;
   logic        w_drain1;
   logic        w_kill_own;
   logic        w_room;
   logic        w_adv;
   logic        w_s1_kill;
   logic        w_can;
   logic        w_elig0;
   logic        w_elig1;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_acc;
   logic [31:0] w_prod;

   calc_mul u_calc_mul (
      .a  (r_s1_a),
      .b  (r_s1_b),
      .m  (r_s1_m),
      .en (r_s1_valid),
      .p  (w_prod)
   );

   always_comb begin
      w_drain0   = r_r0_valid & RSP0_READY;
      w_drain1   = r_r1_valid & RSP1_READY;
      w_kill_own = r_s1_owner ? KILL1 : KILL0;
      w_room     = r_s1_owner ? (~r_r1_valid | w_drain1) : (~r_r0_valid | w_drain0);
      w_adv      = r_s1_valid & w_room & ~w_kill_own;
      w_s1_kill  = r_s1_valid & w_kill_own;
      w_can      = ~r_s1_valid | w_adv | w_s1_kill;
      w_elig0    = REQ0_VALID & ~KILL0;
      w_elig1    = REQ1_VALID & ~KILL1;
      w_grant0   = w_elig0 & (~w_elig1 | ~r_pri);
      w_grant1   = w_elig1 & (~w_elig0 | r_pri);
      // Ready is held low while reset is asserted so all outputs read 0.
      REQ0_READY = RSTn & w_can & w_grant0;
      REQ1_READY = RSTn & w_can & w_grant1;
      w_acc      = REQ0_READY | REQ1_READY;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_s1_valid <= 1'b0;
         r_s1_owner <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_m     <= '0;
         r_pri      <= 1'b0;
      end else begin
         if (w_acc) begin
            r_s1_valid <= 1'b1;
            r_s1_owner <= REQ1_READY;
            r_s1_a     <= REQ1_READY ? REQ1_A : REQ0_A;
            r_s1_b     <= REQ1_READY ? REQ1_B : REQ0_B;
            r_s1_m     <= REQ1_READY ? REQ1_M : REQ0_M;
            r_pri      <= ~REQ1_READY;
         end else if (w_adv || w_s1_kill) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   // Kill wins over advance and drain; an advance landing on a draining
   // register keeps it valid with the new product.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_r0_valid <= 1'b0;
         r_r0_data  <= '0;
         r_r1_valid <= 1'b0;
         r_r1_data  <= '0;
      end else begin
         if (KILL0) begin
            r_r0_valid <= 1'b0;
         end else if (w_adv && !r_s1_owner) begin
            r_r0_valid <= 1'b1;
            r_r0_data  <= w_prod;
         end else if (w_drain0) begin
            r_r0_valid <= 1'b0;
         end
         if (KILL1) begin
            r_r1_valid <= 1'b0;
         end else if (w_adv && r_s1_owner) begin
            r_r1_valid <= 1'b1;
            r_r1_data  <= w_prod;
         end else if (w_drain1) begin
            r_r1_valid <= 1'b0;
         end
      end
   end

   assign RSP0_VALID = r_r0_valid;
   assign RSP1_VALID = r_r1_valid;
   assign RSP0_DATA  = r_r0_data;
   assign RSP1_DATA  = r_r1_data;
   assign BUSY       = r_s1_valid | r_r0_valid | r_r1_valid;
endmodule

`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_sched
// Brief    : Directed self-checking bench for mul_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_sched;
   logic        CLK;
   logic        RSTn;
   logic        REQ0_VALID, REQ1_VALID;
   logic        REQ0_READY, REQ1_READY;
   logic [15:0] REQ0_A, REQ1_A, REQ0_B, REQ1_B;
   logic [2:0]  REQ0_M, REQ1_M;
   logic        KILL0, KILL1;
   logic        RSP0_VALID, RSP1_VALID;
   logic        RSP0_READY, RSP1_READY;
   logic [31:0] RSP0_DATA, RSP1_DATA;
   logic        BUSY;

   int checks;
   int failures;

   mul_sched dut (
      .CLK(CLK), .RSTn(RSTn),
      .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
      .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
      .REQ0_A(REQ0_A), .REQ1_A(REQ1_A),
      .REQ0_B(REQ0_B), .REQ1_B(REQ1_B),
      .REQ0_M(REQ0_M), .REQ1_M(REQ1_M),
      .KILL0(KILL0), .KILL1(KILL1),
      .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
      .RSP0_READY(RSP0_READY), .RSP1_READY(RSP1_READY),
      .RSP0_DATA(RSP0_DATA), .RSP1_DATA(RSP1_DATA),
      .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Single req0 op; result must appear exactly two edges after accept.
   task automatic single0(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] m, input logic [31:0] exp);
      REQ0_VALID = 1'b1; REQ0_A = a; REQ0_B = b; REQ0_M = m;
      #1 chk1({tag, "_ready"}, REQ0_READY, 1'b1);
      tick();
      REQ0_VALID = 1'b0;
      chk1({tag, "_early"}, RSP0_VALID, 1'b0);
      tick();
      chk1({tag, "_valid"}, RSP0_VALID, 1'b1);
      chk32({tag, "_data"}, RSP0_DATA, exp);
      tick();
      chk1({tag, "_drained"}, RSP0_VALID, 1'b0);
   endtask

   int exp_f[6] = '{10, 14, 15, 16, 20, 18};

   initial begin
      checks = 0; failures = 0;
      RSTn = 1'b0;
      REQ0_VALID = 1'b1; REQ1_VALID = 1'b0;
      REQ0_A = '0; REQ1_A = '0; REQ0_B = '0; REQ1_B = '0;
      REQ0_M = '0; REQ1_M = '0;
      KILL0 = 1'b0; KILL1 = 1'b0;
      RSP0_READY = 1'b1; RSP1_READY = 1'b1;
      #2;
      chk1("rst_ready0", REQ0_READY, 1'b0);
      chk1("rst_rsp0_valid", RSP0_VALID, 1'b0);
      chk1("rst_rsp1_valid", RSP1_VALID, 1'b0);
      chk32("rst_rsp0_data", RSP0_DATA, 32'h0);
      chk32("rst_rsp1_data", RSP1_DATA, 32'h0);
      chk1("rst_busy", BUSY, 1'b0);
      REQ0_VALID = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      RSTn = 1'b1;

      // Fairness: both requesters continuously valid.
      for (int c = 0; c < 8; c++) begin
         if (c >= 2) begin
            if ((c % 2) == 0) begin
               chk1("fair_rsp0_valid", RSP0_VALID, 1'b1);
               chk32("fair_rsp0_data", RSP0_DATA, exp_f[c-2]);
               chk1("fair_rsp1_idle", RSP1_VALID, 1'b0);
            end else begin
               chk1("fair_rsp1_valid", RSP1_VALID, 1'b1);
               chk32("fair_rsp1_data", RSP1_DATA, exp_f[c-2]);
               chk1("fair_rsp0_idle", RSP0_VALID, 1'b0);
            end
         end
         if (c < 6) begin
            REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
            REQ0_A = 16'(2 + c/2); REQ0_B = 16'd5;
            REQ1_A = 16'(7 + c/2); REQ1_B = 16'd2;
            #1;
            chk1("fair_ready0", REQ0_READY, (c % 2) == 0);
            chk1("fair_ready1", REQ1_READY, (c % 2) == 1);
         end else begin
            REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
         end
         tick();
      end

      // Modes.
      single0("m000", 16'hFFFF, 16'hFFFF, 3'b000, 32'h00000001);
      single0("m011", 16'hFFFF, 16'hFFFF, 3'b011, 32'hFFFE0001);
      single0("m111", 16'hFFFF, 16'hFFFF, 3'b111, 32'h0000FFFE);
      single0("m000_min", 16'h8000, 16'h8000, 3'b000, 32'h40000000);
      single0("m010", 16'hFFFF, 16'hFFFF, 3'b010, 32'hFFFF0001);
      single0("m100_neg", 16'hFFFE, 16'h0003, 3'b100, 32'h0000FFFF);

      // Backpressure on req0, then drain with back-to-back refill.
      RSP0_READY = 1'b0;
      REQ0_VALID = 1'b1; REQ0_A = 16'd1; REQ0_B = 16'd3; REQ0_M = 3'b000;
      #1 chk1("bp_acc1", REQ0_READY, 1'b1);
      tick();
      REQ0_A = 16'd2;
      #1 chk1("bp_acc2", REQ0_READY, 1'b1);
      tick();
      REQ0_A = 16'd3; REQ1_VALID = 1'b1; REQ1_A = 16'd1; REQ1_B = 16'd1;
      chk1("bp_busy", BUSY, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk1("bp_stall_valid", RSP0_VALID, 1'b1);
         chk32("bp_stall_data", RSP0_DATA, 32'd3);
         #1;
         chk1("bp_stall_ready0", REQ0_READY, 1'b0);
         chk1("bp_stall_ready1", REQ1_READY, 1'b0);
         tick();
      end
      REQ1_VALID = 1'b0;
      RSP0_READY = 1'b1;
      #1 chk1("bp_resume_acc3", REQ0_READY, 1'b1);
      tick();
      chk1("bp_r6_valid", RSP0_VALID, 1'b1);
      chk32("bp_r6", RSP0_DATA, 32'd6);
      REQ0_A = 16'd4;
      #1 chk1("bp_acc4", REQ0_READY, 1'b1);
      tick();
      REQ0_VALID = 1'b0;
      chk1("bp_r9_valid", RSP0_VALID, 1'b1);
      chk32("bp_r9", RSP0_DATA, 32'd9);
      tick();
      chk1("bp_r12_valid", RSP0_VALID, 1'b1);
      chk32("bp_r12", RSP0_DATA, 32'd12);
      tick();
      chk1("bp_done", RSP0_VALID, 1'b0);

      // Kill of an in-flight req1 op while req0 keeps issuing.
      REQ1_VALID = 1'b1; REQ1_A = 16'd5; REQ1_B = 16'd5; REQ1_M = 3'b000;
      #1 chk1("kill_acc1", REQ1_READY, 1'b1);
      tick();
      KILL1 = 1'b1;
      REQ0_VALID = 1'b1; REQ0_A = 16'd6; REQ0_B = 16'd6;
      #1;
      chk1("kill_ready1", REQ1_READY, 1'b0);
      chk1("kill_ready0", REQ0_READY, 1'b1);
      tick();
      KILL1 = 1'b0; REQ1_VALID = 1'b0; REQ0_VALID = 1'b0;
      chk1("kill_rsp1_a", RSP1_VALID, 1'b0);
      tick();
      chk1("kill_rsp1_b", RSP1_VALID, 1'b0);
      chk1("kill_rsp0_valid", RSP0_VALID, 1'b1);
      chk32("kill_rsp0_data", RSP0_DATA, 32'd36);
      tick();
      chk1("kill_rsp1_c", RSP1_VALID, 1'b0);
      chk1("kill_busy", BUSY, 1'b0);

      // Fill S1, R0, R1 then reset mid-cycle.
      RSP0_READY = 1'b0; RSP1_READY = 1'b0;
      REQ0_VALID = 1'b1; REQ0_A = 16'd2; REQ0_B = 16'd2;
      tick();
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b1; REQ1_A = 16'd3; REQ1_B = 16'd3;
      tick();
      REQ1_VALID = 1'b0;
      REQ0_VALID = 1'b1; REQ0_A = 16'd4; REQ0_B = 16'd4;
      tick();
      chk1("mid_r0", RSP0_VALID, 1'b1);
      chk32("mid_r0_data", RSP0_DATA, 32'd4);
      chk1("mid_r1", RSP1_VALID, 1'b1);
      chk32("mid_r1_data", RSP1_DATA, 32'd9);
      chk1("mid_busy", BUSY, 1'b1);
      REQ0_VALID = 1'b1; REQ0_A = 16'd7; REQ0_B = 16'd7;
      REQ1_VALID = 1'b1; REQ1_A = 16'd8; REQ1_B = 16'd8;
      #2 RSTn = 1'b0;
      #1;
      chk1("arst_rsp0", RSP0_VALID, 1'b0);
      chk1("arst_rsp1", RSP1_VALID, 1'b0);
      chk32("arst_data0", RSP0_DATA, 32'h0);
      chk32("arst_data1", RSP1_DATA, 32'h0);
      chk1("arst_busy", BUSY, 1'b0);
      chk1("arst_ready0", REQ0_READY, 1'b0);
      chk1("arst_ready1", REQ1_READY, 1'b0);
      tick();
      RSTn = 1'b1;
      RSP0_READY = 1'b1; RSP1_READY = 1'b1;
      #1;
      chk1("post_rst_ready0", REQ0_READY, 1'b1);
      chk1("post_rst_ready1", REQ1_READY, 1'b0);
      tick();
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      tick();
      chk1("post_rst_rsp0", RSP0_VALID, 1'b1);
      chk32("post_rst_data0", RSP0_DATA, 32'd49);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mul_sched.md
# mul_sched

Two-requester scheduler for the shared 16×16 Booth multiplier (`calc_mul`) in the execute stage. It arbitrates round-robin between two issue ports and registers operands into a single issue stage. It steers each product into a per-requester result register with a valid/ready return handshake, and supports per-requester kill for pipeline flush. One combinational `calc_mul` instance is shared; total throughput is one multiply per cycle.

## Interface
Parameters:
- none (widths fixed: 16-bit operands, 32-bit result)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  reset, asynchronous assert, active-low
- REQ0_VALID, REQ1_VALID  in  1  requester i presents an operation
- REQ0_READY, REQ1_READY  out  1  requester i operation accepted this cycle (handshake = VALID & READY)
- REQ0_A, REQ1_A  in  16  multiplicand
- REQ0_B, REQ1_B  in  16  multiplier
- REQ0_M, REQ1_M  in  3  mode: [2]=return high half, [1]=A unsigned, [0]=B unsigned
- KILL0, KILL1  in  1  drop all in-flight work owned by requester i
- RSP0_VALID, RSP1_VALID  out  1  result register i holds a result
- RSP0_READY, RSP1_READY  in  1  requester i consumes result this cycle
- RSP0_DATA, RSP1_DATA  out  32  result
- BUSY  out  1  any of S1, R0, R1 valid

## Operation
- State: issue stage S1 (valid, owner bit, A, B, M); result registers R0, R1 (valid, 32-bit data); round-robin pointer PRI (1 bit, requester with priority).
- Arithmetic: P = A×B as 32-bit two's complement, with A signed unless M[1]=1 and B signed unless M[0]=1.
  - Result = M[2] ? {16'h0, P[31:16]} : P.
  - Computed by `calc_mul(a=S1.A, b=S1.B, m=S1.M, EN=S1.valid)`.
- Drain: Ri.valid clears on RSPi_VALID & RSPi_READY.
- Advance: S1 moves into R[owner] when S1.valid and (R[owner] empty, or draining this cycle), and KILL[owner]=0.
- Kill, requester k:
  - S1 with owner k is invalidated; Rk is invalidated.
  - REQk_READY is forced 0.
  - Kill has priority over drain and advance. RSPk_VALID still reflects the pre-edge state during the kill cycle.
- S1 can accept (CAN) when S1 empty, S1 advancing, or S1 killed this cycle.
- Arbitration:
  - Eligible i: REQi_VALID & !KILLi.
  - If both are eligible, grant PRI; otherwise grant the single eligible one.
  - REQi_READY = CAN & granted(i).
  - On accept of requester g, PRI ← ~g. PRI is unchanged when there is no accept.
- Head-of-line blocking is intended: S1 stalled on a full R[owner] blocks both requesters.
- No result reordering within a requester: results return in acceptance order. At most 2 results are in flight per requester.

## Timing
- Reset (RSTn=0, asynchronous): S1.valid=0, R0.valid=R1.valid=0, PRI=0. All outputs 0: REQi_READY=0, RSPi_VALID=0, RSPi_DATA=32'h0, BUSY=0.
- REQi_READY is combinational from REQ*_VALID, KILL*, RSP*_READY and state. RSPi_VALID, RSPi_DATA and BUSY are registered.
- Latency:
  - Accept at edge k → S1 valid after edge k, Ri loaded at edge k+1.
  - RSPi_VALID=1 in the cycle after edge k+1, i.e. 2 cycles after acceptance with no backpressure.
- Back-to-back: accepts on consecutive cycles produce results on consecutive cycles.
- Stalled S1 holds its contents unchanged; REQ*_READY=0 while stalled.
- RSPi_DATA is stable while RSPi_VALID=1 and not consumed.
- Simultaneous drain of Ri and advance into Ri in the same cycle: the new result is loaded and valid stays 1.
- Reset asserted mid-operation discards everything immediately. The first accept after release is granted to requester 0 if both are valid.

## Test plan
- Modes: single req0, A=0xFFFF, B=0xFFFF.
  - M=000 → RSP0_DATA=0x00000001.
  - M=011 → 0xFFFE0001.
  - M=111 → 0x0000FFFE.
  - M=000 with A=B=0x8000 → 0x40000000.
  - Each result arrives exactly 2 cycles after accept.
- Fairness: both VALID held high for 6 cycles, RSP_READY=1 → accepts alternate 0,1,0,1,0,1 starting with 0. One accept per cycle; each requester receives its 3 results in order.
- Backpressure: req0 streams 4 ops (A=1..4, B=3), RSP0_READY=0.
  - Exactly 2 accepts occur: R0 fills, then S1 holds the second op.
  - REQ0_READY=0 and REQ1_READY=0 afterwards.
  - Raising RSP0_READY returns 3, 6, 9, 12 in order with no loss.
- Kill: accept req1 op, assert KILL1 the next cycle with REQ1_VALID=1.
  - No RSP1_VALID ever appears for that op.
  - REQ1_READY=0 in the kill cycle; req0 is unaffected.
  - BUSY=0 afterwards if req0 is idle.
- Drain/refill: R0 full and RSP0_READY=1 in the same cycle S1 (owner 0) advances → RSP0_VALID stays 1 with the new data the next cycle; no bubble.
- Reset mid-flight: RSTn low for 1 cycle with S1, R0, R1 valid → all outputs 0 immediately (asynchronous). After release with both requesters valid, the first grant goes to requester 0.
